// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M iterative multiply/divide unit.
// Op decoding follows the func_3 field of the M-extension instructions.
package muldiv_pkg;

    localparam int MD_XLEN = 32;
    localparam logic [MD_XLEN-1:0] MIN_INT = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic op_a_signed(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_iter_datapath.sv
// Iterative datapath: one shift-add multiply or restoring divide step per cycle on operand
// magnitudes, with sign fix-up and result selection on the post-step accumulator value.
module muldiv_iter_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  muldiv_op_t      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result
);

    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if_wide(input logic n, input logic [2*XLEN-1:0] v);
        return n ? -v : v;
    endfunction

    muldiv_op_t      r_op;
    logic            r_sign_a;
    logic            r_sign_b;
    logic [XLEN-1:0] r_opnd;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN+1:0] w_div_diff;
    logic            w_div_ok;
    logic [XLEN-1:0] w_hi_nxt;
    logic [XLEN-1:0] w_lo_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;

    assign w_sign_a = op_a_signed(i_op) & i_a[XLEN-1];
    assign w_sign_b = op_b_signed(i_op) & i_b[XLEN-1];
    assign w_mag_a  = neg_if(w_sign_a, i_a);
    assign w_mag_b  = neg_if(w_sign_b, i_b);

    // Multiply: {hi,lo} starts as {0,|b|}; add |a| into hi when lo[0] is set, then shift right.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

    // Divide: {hi,lo} starts as {0,|a|}; shift left one bit and keep the trial subtraction if it fits.
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
    assign w_div_ok    = ~w_div_diff[XLEN+1];

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (op_is_div(r_op)) begin
            w_hi_nxt = w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_div_ok};
        end else begin
            w_hi_nxt = w_mul_sum[XLEN:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (i_load) begin
            r_op     <= i_op;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_opnd   <= op_is_div(i_op) ? w_mag_b : w_mag_a;
            r_hi     <= '0;
            r_lo     <= op_is_div(i_op) ? w_mag_a : w_mag_b;
        end else if (i_step) begin
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    // The result is taken from the post-step value so the sequencer can register it on the last step.
    assign w_prod = neg_if_wide(r_sign_a ^ r_sign_b, {w_hi_nxt, w_lo_nxt});
    assign w_quo  = neg_if(r_sign_a ^ r_sign_b, w_lo_nxt);
    assign w_rem  = neg_if(r_sign_a, w_hi_nxt);

    always_comb begin
        o_result = '0;
        case (r_op)
            OP_MUL:                       o_result = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              o_result = w_quo;
            OP_REM, OP_REMU:              o_result = w_rem;
            default:                      o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage RV32M sequencer: accepts an M-ext op, stalls the pipeline while the iterative
// datapath runs, and pulses result_valid for one cycle when the rd value is ready.
module ex_muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func_3_bits,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] L_MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t   r_state;
    muldiv_state_t   w_next;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0] r_result;

    muldiv_op_t      w_op;
    logic            w_b_zero;
    logic            w_overflow;
    logic            w_special;
    logic            w_accept;
    logic            w_last;
    logic [XLEN-1:0] w_spec_result;
    logic [XLEN-1:0] w_dp_result;

    assign w_op       = muldiv_op_t'(func_3_bits);
    assign w_b_zero   = (operand_b == '0);
    assign w_overflow = op_a_signed(w_op) & (operand_a == L_MIN_INT) & (operand_b == '1);
    assign w_special  = op_is_div(w_op) & (w_b_zero | w_overflow);
    assign w_accept   = (r_state == IDLE) & start & ~flush;
    assign w_last     = (r_state == BUSY) & ~flush & (r_count == '0);

    // Divide-by-zero and signed overflow are answered directly without iterating.
    always_comb begin
        w_spec_result = '0;
        if (op_is_rem(w_op)) begin
            w_spec_result = w_b_zero ? operand_a : '0;
        end else begin
            w_spec_result = w_b_zero ? '1 : L_MIN_INT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start && !flush) begin
                    w_next = w_special ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    w_next = IDLE;
                end else if (r_count == '0) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            IDLE: stall = start & ~flush;
            BUSY: begin
                stall = ~flush;
                busy  = 1'b1;
            end
            DONE: begin
                busy         = 1'b1;
                result_valid = ~flush;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= CNT_W'(XLEN - 1);
        end else if (r_state == BUSY && r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_accept && w_special) begin
            r_result <= w_spec_result;
        end else if (w_last) begin
            r_result <= w_dp_result;
        end
    end

    assign result = r_result;

    muldiv_iter_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept & ~w_special),
        .i_step   (r_state == BUSY),
        .i_op     (w_op),
        .i_a      (operand_a),
        .i_b      (operand_b),
        .o_result (w_dp_result)
    );

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed bench for ex_muldiv_sequencer: results, stall/valid timing, specials, flush and reset.
module tb_ex_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  func_3_bits;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;

    int  n_checks = 0;
    int  n_errors = 0;
    time t_valid  = 0;

    always #5 clk = ~clk;

    ex_muldiv_sequencer #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .func_3_bits  (func_3_bits),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, hold start while stalled, and measure latency and stall cycles.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] exp_res, input int exp_lat);
        int          cyc;
        int          nstall;
        bit          got;
        logic [31:0] res;
        @(negedge clk);
        start = 1'b1;
        func_3_bits = op;
        operand_a = va;
        operand_b = vb;
        cyc = 0;
        nstall = 0;
        got = 1'b0;
        res = '0;
        while (!got && cyc < 100) begin
            #1;
            if (stall) nstall++;
            if (result_valid) begin
                got = 1'b1;
                res = result;
                t_valid = $time;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check_eq({tag, "_valid"}, 32'(got), 32'd1);
        check_eq({tag, "_res"}, res, exp_res);
        check_eq({tag, "_lat"}, cyc, exp_lat);
        check_eq({tag, "_stall"}, nstall, exp_lat);
    endtask

    initial begin
        time t_first;
        int  seen;
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        func_3_bits = 3'd0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_result", result, 32'd0);
        rst = 1'b0;

        run_op("mul_7_m3",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhsu_m1",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_op("divu_100_7",  3'd5, 32'd100,      32'd7,        32'd14,        33);
        run_op("remu_100_7",  3'd7, 32'd100,      32'd7,        32'd2,         33);
        run_op("divu_by0",    3'd5, 32'd100,      32'd0,        32'hFFFF_FFFF, 1);
        run_op("rem_by0",     3'd6, 32'd100,      32'd0,        32'd100,       1);
        run_op("div_ovf",     3'd4, MIN_INT,      32'hFFFF_FFFF, MIN_INT,      1);
        run_op("rem_ovf",     3'd6, MIN_INT,      32'hFFFF_FFFF, 32'd0,        1);

        // Flush at BUSY iteration 10
        @(negedge clk);
        start = 1'b1;
        func_3_bits = 3'd0;
        operand_a = 32'd5;
        operand_b = 32'd6;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        start = 1'b0;
        #1;
        check_eq("flush_stall", 32'(stall), 32'd0);
        check_eq("flush_busy_same", 32'(busy), 32'd1);
        check_eq("flush_valid_same", 32'(result_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_eq("flush_busy_next", 32'(busy), 32'd0);
        check_eq("flush_stall_next", 32'(stall), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (result_valid) seen = 1;
        end
        check_eq("flush_no_valid", seen, 32'd0);
        run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        // Flush and start together: not accepted
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        func_3_bits = 3'd5;
        operand_a = 32'd100;
        operand_b = 32'd7;
        #1;
        check_eq("fs_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        check_eq("fs_busy", 32'(busy), 32'd0);

        // Back-to-back MUL then DIV
        run_op("b2b_mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        t_first = t_valid;
        run_op("b2b_div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        check_eq("b2b_gap", 32'((t_valid - t_first) / 10), 32'd34);

        // Reset pulse in the middle of a DIV
        @(negedge clk);
        start = 1'b1;
        func_3_bits = 3'd5;
        operand_a = 32'd100;
        operand_b = 32'd7;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        #1;
        check_eq("mrst_stall", 32'(stall), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_valid", 32'(result_valid), 32'd0);
        check_eq("mrst_result", result, 32'd0);
        run_op("post_rst_remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
